// File: rtl/stream_cipher_pkg.sv
// Shared types for the stream cipher.
// Interface FSM state and command FIFO payloads.
package stream_cipher_pkg;

  typedef enum logic [1:0] {
    IDLE,
    KEY_LOAD,
    RUN,
    HASH
  } interface_state_t;

  typedef enum logic {
    CMD_BYTE  = 1'b0,
    CMD_RESET = 1'b1
  } cmd_kind_t;

  localparam int CMD_DATA_W = 8;

  typedef struct packed {
    cmd_kind_t             kind;
    logic                  is_key;
    logic [CMD_DATA_W-1:0] data;
  } cmd_t;

  typedef enum logic {
    H_IDLE,
    H_WAIT_LOW
  } hs_state_t;

endpackage

// File: rtl/handshake_reader_if.sv
// Pin-side 4-phase request/acknowledge bundle.
// Master is the host, slave is the reader.
interface handshake_reader_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] input_byte;
  logic              is_key;
  logic              reset_hash;
  logic              input_request;
  logic              input_ack;

  modport master (
    output input_byte,
    output is_key,
    output reset_hash,
    output input_request,
    input  input_ack
  );

  modport slave (
    input  input_byte,
    input  is_key,
    input  reset_hash,
    input  input_request,
    output input_ack
  );
endinterface

// File: rtl/handshake_reader_cmd_fifo.sv
// Small synchronous FIFO for queued commands.
// Depth is a power of two so pointers wrap naturally.
module cmd_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Next storage, pointers and occupancy
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) begin
      mem_d[wptr_q] = wdata;
      wptr_d        = wptr_q + AW'(1);
    end
    if (pop_ok) begin
      rptr_d = rptr_q + AW'(1);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/handshake_reader.sv
// Pin-side input front end: sync, accept FSM,
// command FIFO and single-cycle release strobes.
module handshake_reader
  import stream_cipher_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              nrst,
  handshake_reader_if.slave pins,
  input  interface_state_t  fsm_state,
  output logic [DATA_W-1:0] input_byte_pulsed,
  output logic              is_key_pulsed,
  output logic              input_byte_pulse,
  output logic              reset_hash_pulse,
  output logic [CW-1:0]     fifo_count
);

  typedef struct packed {
    cmd_kind_t         kind;
    logic              is_key;
    logic [DATA_W-1:0] data;
  } cmd_w_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   req_s;
  hs_state_t              hs_q, hs_d;
  logic                   ack_q, ack_d;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   empty;
  cmd_w_t                 wcmd;
  cmd_w_t                 rcmd;
  logic                   bp_q, bp_d;
  logic                   hp_q, hp_d;
  logic [DATA_W-1:0]      bd_q, bd_d;
  logic                   bk_q, bk_d;

  assign req_s = sync_q[SYNC_STAGES-1];

  // Shift the raw request through the synchroniser
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pins.input_request};
  end

  // Build the command; data pins ignored for reset
  always_comb begin
    wcmd        = '0;
    wcmd.kind   = pins.reset_hash ? CMD_RESET : CMD_BYTE;
    wcmd.is_key = pins.reset_hash ? 1'b0 : pins.is_key;
    wcmd.data   = pins.reset_hash ? '0 : pins.input_byte;
  end

  // Accept FSM: one push per request high phase
  always_comb begin
    hs_d  = hs_q;
    ack_d = ack_q;
    push  = 1'b0;
    unique case (hs_q)
      H_IDLE: begin
        if (req_s && !full) begin
          push  = 1'b1;
          ack_d = 1'b1;
          hs_d  = H_WAIT_LOW;
        end
      end
      H_WAIT_LOW: begin
        if (!req_s) begin
          ack_d = 1'b0;
          hs_d  = H_IDLE;
        end
      end
      default: begin
        hs_d  = H_IDLE;
        ack_d = 1'b0;
      end
    endcase
  end

  cmd_fifo #(
    .WIDTH ($bits(cmd_w_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (push),
    .wdata (wcmd),
    .pop   (pop),
    .rdata (rcmd),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // Release: pop only when idle and no strobe is up
  always_comb begin
    pop  = (fsm_state == IDLE) && !empty
        && !bp_q && !hp_q;
    bp_d = 1'b0;
    hp_d = 1'b0;
    bd_d = '0;
    bk_d = 1'b0;
    if (pop) begin
      unique case (1'b1)
        (rcmd.kind == CMD_RESET): begin
          hp_d = 1'b1;
        end
        default: begin
          bp_d = 1'b1;
          bd_d = rcmd.data;
          bk_d = rcmd.is_key;
        end
      endcase
    end
  end

  // Synchroniser, FSM and output registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q <= '0;
      hs_q   <= H_IDLE;
      ack_q  <= 1'b0;
      bp_q   <= 1'b0;
      hp_q   <= 1'b0;
      bd_q   <= '0;
      bk_q   <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hs_q   <= hs_d;
      ack_q  <= ack_d;
      bp_q   <= bp_d;
      hp_q   <= hp_d;
      bd_q   <= bd_d;
      bk_q   <= bk_d;
    end
  end

  assign pins.input_ack    = ack_q;
  assign input_byte_pulse  = bp_q;
  assign reset_hash_pulse  = hp_q;
  assign input_byte_pulsed = bd_q;
  assign is_key_pulsed     = bk_q;

endmodule
